// File: rtl/qdec_cabac_package.sv
`default_nettype none
// ============================================================================
// Module      : qdec_cabac_package
// Description : Shared register map, FSM states, error codes and helpers for
//               the CABAC decoder control block.
// Revision    : 1.0 - initial release
// ============================================================================
package qdec_cabac_package;

    // CABAC register map
    localparam logic [15:0] ADDR_CABAC_VPS_0          = 16'h0000;
    localparam logic [15:0] ADDR_CABAC_SPS_0          = 16'h0004;
    localparam logic [15:0] ADDR_CABAC_SPS_1          = 16'h0008;
    localparam logic [15:0] ADDR_CABAC_PPS_0          = 16'h000C;
    localparam logic [15:0] ADDR_CABAC_SLICE_HEADER_0 = 16'h0010;
    localparam logic [15:0] ADDR_CABAC_START          = 16'h0014;

    // Number of host-programmable shadow registers
    localparam int NUM_CFG = 5;

    // Control FSM states; DRAIN waits for an in-flight read after abort
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5,
        ST_DRAIN = 3'd6
    } cabacState_t;

    // Error codes reported on err_code
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_VERIFY  = 3'd1,
        ERR_CABAC   = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_ABORT   = 3'd4
    } cabacErr_t;

    // Shadow index to CABAC register address
    function automatic logic [15:0] cfgAddr(input logic [2:0] idx);
        logic [15:0] addr;
        case (idx)
            3'd0:    addr = ADDR_CABAC_VPS_0;
            3'd1:    addr = ADDR_CABAC_SPS_0;
            3'd2:    addr = ADDR_CABAC_SPS_1;
            3'd3:    addr = ADDR_CABAC_PPS_0;
            3'd4:    addr = ADDR_CABAC_SLICE_HEADER_0;
            default: addr = ADDR_CABAC_VPS_0;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qdec_cabac_ctrl_regmst.sv
`default_nettype none
// ============================================================================
// Module      : qdec_cabac_ctrl_regmst
// Description : Single-outstanding register master. Holds a request stable
//               until accepted and tracks one pending read response.
// Revision    : 1.0 - initial release
// ============================================================================
module qdec_cabac_ctrl_regmst (
    input  logic        clk,
    input  logic        rst,
    // command side (from control FSM)
    input  logic        i_cmdVld,
    input  logic        i_cmdWe,
    input  logic [15:0] i_cmdAddr,
    input  logic [31:0] i_cmdWdata,
    input  logic        i_drop,
    output logic        o_cmdRdy,
    output logic        o_ack,
    output logic        o_rspVld,
    output logic [31:0] o_rspData,
    output logic        o_idle,
    // register bus
    output logic        o_regVld,
    output logic        o_regWe,
    output logic [15:0] o_regAddr,
    output logic [31:0] o_regWdata,
    input  logic        i_regRdy,
    input  logic        i_regRvld,
    input  logic [31:0] i_regRdata
);

    logic        r_vld;
    logic        r_we;
    logic        r_rdPend;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;

    // New commands only when nothing is presented and no read is pending
    assign o_cmdRdy   = ~r_vld & ~r_rdPend;
    assign o_ack      = r_vld & i_regRdy;
    assign o_rspVld   = r_rdPend & i_regRvld;
    assign o_rspData  = i_regRdata;
    assign o_idle     = ~r_vld & ~r_rdPend;

    assign o_regVld   = r_vld;
    assign o_regWe    = r_we;
    assign o_regAddr  = r_addr;
    assign o_regWdata = r_wdata;

    // Request register and read-outstanding tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= 1'b0;
            r_we     <= 1'b0;
            r_rdPend <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            // acceptance beats drop: an accepted read must still be answered
            if (o_ack) begin
                r_vld <= 1'b0;
                if (!r_we) begin
                    r_rdPend <= 1'b1;
                end
            end else if (i_drop) begin
                r_vld <= 1'b0;
            end
            if (o_rspVld) begin
                r_rdPend <= 1'b0;
            end
            if (i_cmdVld && o_cmdRdy && !i_drop) begin
                r_vld   <= 1'b1;
                r_we    <= i_cmdWe;
                r_addr  <= i_cmdAddr;
                r_wdata <= i_cmdWdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qdec_cabac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qdec_cabac_ctrl
// Description : CABAC decoder control: programs config registers, optionally
//               verifies them, starts decode, tracks CTUs with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module qdec_cabac_ctrl
    import qdec_cabac_package::*;
#(
    parameter int TIMEOUT_W = 24,
    parameter int VERIFY_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    // host
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_idx,
    input  logic [31:0]          cfg_wdata,
    input  logic                 go,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    // register master
    output logic                 reg_vld,
    output logic                 reg_we,
    output logic [15:0]          reg_addr,
    output logic [31:0]          reg_wdata,
    input  logic                 reg_rdy,
    input  logic                 reg_rvld,
    input  logic [31:0]          reg_rdata,
    // CABAC events
    input  logic                 ctu_done_intr,
    input  logic                 done_intr,
    input  logic                 error_intr,
    // status
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [15:0]          ctu_cnt
);

    cabacState_t          r_state;
    cabacState_t          w_stateNext;
    logic [31:0]          r_shadow [NUM_CFG];
    logic [2:0]           r_idx;
    logic                 r_sent;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [15:0]          r_ctuCnt;
    logic                 r_done;
    logic                 r_err;
    cabacErr_t            r_errCode;
    cabacErr_t            w_errCode;

    logic                 w_cmdVld;
    logic                 w_cmdWe;
    logic [15:0]          w_cmdAddr;
    logic [31:0]          w_cmdWdata;
    logic                 w_drop;
    logic                 w_cmdRdy;
    logic                 w_ack;
    logic                 w_rspVld;
    logic [31:0]          w_rspData;
    logic                 w_mstIdle;
    logic                 w_lastIdx;
    logic [TIMEOUT_W:0]   w_wdogInc;
    logic                 w_wdogHit;
    logic                 w_goStart;

    assign w_lastIdx = (r_idx == 3'd4);
    assign w_wdogInc = {1'b0, r_wdog} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // A CTU completion this cycle restarts the watchdog, so it cannot expire
    assign w_wdogHit = (timeout_lim != '0) && !ctu_done_intr
                       && (w_wdogInc >= {1'b0, timeout_lim});
    assign w_goStart = (w_stateNext == ST_WR)
                       && ((r_state == ST_IDLE) || (r_state == ST_ERR));

    qdec_cabac_ctrl_regmst u_regmst (
        .clk        (clk),
        .rst        (rst),
        .i_cmdVld   (w_cmdVld),
        .i_cmdWe    (w_cmdWe),
        .i_cmdAddr  (w_cmdAddr),
        .i_cmdWdata (w_cmdWdata),
        .i_drop     (w_drop),
        .o_cmdRdy   (w_cmdRdy),
        .o_ack      (w_ack),
        .o_rspVld   (w_rspVld),
        .o_rspData  (w_rspData),
        .o_idle     (w_mstIdle),
        .o_regVld   (reg_vld),
        .o_regWe    (reg_we),
        .o_regAddr  (reg_addr),
        .o_regWdata (reg_wdata),
        .i_regRdy   (reg_rdy),
        .i_regRvld  (reg_rvld),
        .i_regRdata (reg_rdata)
    );

    // Host shadow registers, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (cfg_we && (r_state == ST_IDLE) && (cfg_idx <= 3'd4)) begin
            r_shadow[cfg_idx] <= cfg_wdata;
        end
    end

    // Next-state, request generation and error-code selection
    always_comb begin
        w_stateNext = r_state;
        w_errCode   = r_errCode;
        w_cmdVld    = 1'b0;
        w_cmdWe     = 1'b0;
        w_cmdAddr   = '0;
        w_cmdWdata  = '0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) w_stateNext = ST_WR;
            end
            ST_WR: begin
                w_cmdVld   = !r_sent;
                w_cmdWe    = 1'b1;
                w_cmdAddr  = cfgAddr(r_idx);
                w_cmdWdata = r_shadow[r_idx];
                if (w_ack && w_lastIdx) begin
                    w_stateNext = (VERIFY_EN != 0) ? ST_RD : ST_START;
                end
            end
            ST_RD: begin
                w_cmdVld  = !r_sent;
                w_cmdAddr = cfgAddr(r_idx);
                if (w_rspVld) begin
                    if (w_rspData != r_shadow[r_idx]) begin
                        w_stateNext = ST_ERR;
                        w_errCode   = ERR_VERIFY;
                    end else if (w_lastIdx) begin
                        w_stateNext = ST_START;
                    end
                end
            end
            ST_START: begin
                w_cmdVld   = !r_sent;
                w_cmdWe    = 1'b1;
                w_cmdAddr  = ADDR_CABAC_START;
                w_cmdWdata = 32'h1;
                if (w_ack) w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                // error beats done beats timeout
                if (error_intr) begin
                    w_stateNext = ST_ERR;
                    w_errCode   = ERR_CABAC;
                end else if (done_intr) begin
                    w_stateNext = ST_IDLE;
                end else if (w_wdogHit) begin
                    w_stateNext = ST_ERR;
                    w_errCode   = ERR_TIMEOUT;
                end
            end
            ST_ERR: begin
                if (go) w_stateNext = ST_WR;
            end
            ST_DRAIN: begin
                if (w_mstIdle) begin
                    w_stateNext = ST_ERR;
                    w_errCode   = ERR_ABORT;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
        // abort overrides everything outside IDLE; DRAIN is already draining
        if (abort && (r_state != ST_IDLE) && (r_state != ST_DRAIN)) begin
            w_stateNext = ST_DRAIN;
            w_cmdVld    = 1'b0;
            w_drop      = 1'b1;
        end
    end

    // State register plus sequencing, counters and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_sent    <= 1'b0;
            r_wdog    <= '0;
            r_ctuCnt  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
        end else begin
            r_state <= w_stateNext;
            r_done  <= (r_state == ST_RUN) && (w_stateNext == ST_IDLE);

            if (w_cmdVld && w_cmdRdy) begin
                r_sent <= 1'b1;
            end

            case (r_state)
                ST_WR: begin
                    if (w_ack) begin
                        r_sent <= 1'b0;
                        r_idx  <= w_lastIdx ? 3'd0 : r_idx + 3'd1;
                    end
                end
                ST_RD: begin
                    if (w_rspVld) begin
                        r_sent <= 1'b0;
                        r_idx  <= w_lastIdx ? 3'd0 : r_idx + 3'd1;
                    end
                end
                ST_START: begin
                    if (w_ack) begin
                        r_sent <= 1'b0;
                        r_wdog <= '0;
                    end
                end
                ST_RUN: begin
                    if (ctu_done_intr) begin
                        r_wdog <= '0;
                        if (r_ctuCnt != 16'hFFFF) r_ctuCnt <= r_ctuCnt + 16'd1;
                    end else if (r_wdog != {TIMEOUT_W{1'b1}}) begin
                        r_wdog <= r_wdog + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase

            if ((w_stateNext == ST_ERR) && (r_state != ST_ERR)) begin
                r_err     <= 1'b1;
                r_errCode <= w_errCode;
            end

            if (w_goStart) begin
                r_ctuCnt  <= '0;
                r_err     <= 1'b0;
                r_errCode <= ERR_NONE;
                r_idx     <= '0;
                r_sent    <= 1'b0;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_errCode;
    assign ctu_cnt  = r_ctuCnt;

endmodule
`default_nettype wire
